// File: rtl/dcache_wb_queue_pkg.sv
// Shared constants for the dcache write-back queue: AXI encodings, drain FSM states,
// and helpers deriving the line offset and AXI beat size from the geometry.
package dcache_wb_queue_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        DRN_IDLE,
        DRN_AW,
        DRN_W,
        DRN_B
    } drain_state_e;

    function automatic int unsigned line_off_w(input int unsigned line_words,
                                               input int unsigned data_w);
        return $clog2(line_words * data_w / 8);
    endfunction

    function automatic logic [2:0] axi_size(input int unsigned data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/dcache_wbq_drain.sv
// Drain engine for the write-back queue: writes the head entry as one INCR burst
// (AW, then W beats, then B) and signals when the head may be freed.
module dcache_wbq_drain
    import dcache_wb_queue_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         head_valid_i,
    input  logic [ADDR_W-1:0]            head_addr_i,
    input  logic [LINE_WORDS*DATA_W-1:0] head_line_i,
    output logic                         idle_o,
    output logic                         free_o,
    output logic                         aw_valid_o,
    input  logic                         aw_ready_i,
    output logic [ADDR_W-1:0]            aw_addr_o,
    output logic [7:0]                   aw_len_o,
    output logic [2:0]                   aw_size_o,
    output logic                         w_valid_o,
    input  logic                         w_ready_i,
    output logic [DATA_W-1:0]            w_data_o,
    output logic [DATA_W/8-1:0]          w_strb_o,
    output logic                         w_last_o,
    input  logic                         b_valid_i,
    output logic                         b_ready_o
);

    localparam int unsigned BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    drain_state_e      state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= DRN_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        aw_valid_o = 1'b0;
        w_valid_o  = 1'b0;
        w_last_o   = 1'b0;
        b_ready_o  = 1'b0;
        free_o     = 1'b0;
        unique case (state_q)
            DRN_IDLE: begin
                if (head_valid_i) state_d = DRN_AW;
            end
            DRN_AW: begin
                aw_valid_o = 1'b1;
                if (aw_ready_i) begin
                    state_d = DRN_W;
                    beat_d  = '0;
                end
            end
            DRN_W: begin
                w_valid_o = 1'b1;
                w_last_o  = (beat_q == LAST_BEAT);
                if (w_ready_i) begin
                    if (beat_q == LAST_BEAT) state_d = DRN_B;
                    else                     beat_d  = beat_q + BEAT_W'(1);
                end
            end
            DRN_B: begin
                b_ready_o = 1'b1;
                // Entry is released only once the response arrives; its code is ignored.
                if (b_valid_i) begin
                    free_o  = 1'b1;
                    state_d = DRN_IDLE;
                end
            end
            default: state_d = DRN_IDLE;
        endcase
    end

    assign idle_o    = (state_q == DRN_IDLE);
    assign aw_addr_o = head_addr_i;
    assign aw_len_o  = 8'(LINE_WORDS - 1);
    assign aw_size_o = axi_size(DATA_W);
    assign w_data_o  = head_line_i[beat_q*DATA_W +: DATA_W];
    assign w_strb_o  = '1;

endmodule

// File: rtl/dcache_wb_queue.sv
// Multi-entry dcache write-back queue: FIFO line storage, refill lookup forwarding
// (youngest match wins), flush handshake, and the AXI drain engine on the head entry.
module dcache_wb_queue
    import dcache_wb_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned LINE_WORDS = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [ADDR_W-1:0]            enq_addr,
    input  logic [LINE_WORDS*DATA_W-1:0] enq_line,
    input  logic [ADDR_W-1:0]            lk_addr,
    output logic                         lk_hit,
    output logic [LINE_WORDS*DATA_W-1:0] lk_line,
    output logic                         aw_valid,
    input  logic                         aw_ready,
    output logic [ADDR_W-1:0]            aw_addr,
    output logic [7:0]                   aw_len,
    output logic [2:0]                   aw_size,
    output logic                         w_valid,
    input  logic                         w_ready,
    output logic [DATA_W-1:0]            w_data,
    output logic [DATA_W/8-1:0]          w_strb,
    output logic                         w_last,
    input  logic                         b_valid,
    output logic                         b_ready,
    input  logic                         flush_req,
    output logic                         flush_done,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned LINE_W = LINE_WORDS * DATA_W;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned OFF    = line_off_w(LINE_WORDS, DATA_W);
    localparam int unsigned TAG_W  = ADDR_W - OFF;

    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [LINE_W-1:0] line_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  head_q, tail_q, lk_idx;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              flush_pend_q, flush_pend_d;
    logic              enq_fire, free, drain_idle;
    logic              unused_addr_bits;

    assign enq_ready = (count_q != CNT_W'(DEPTH)) && !flush_pend_q;
    assign enq_fire  = enq_valid && enq_ready;
    assign unused_addr_bits = ^{enq_addr[OFF-1:0], lk_addr[OFF-1:0]};

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            tag_q[tail_q]  <= enq_addr[ADDR_W-1:OFF];
            line_q[tail_q] <= enq_line;
        end
    end

    // Full blocks enqueue, so tail never lands on the head slot being freed.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            if (enq_fire) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end
            if (free) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            count_q      <= count_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({enq_fire, free})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    assign flush_done   = flush_pend_q && (count_q == '0) && drain_idle;
    assign flush_pend_d = flush_pend_q ? !flush_done : flush_req;

    // Walk oldest to youngest so a later (re-evicted) copy overrides an earlier one.
    always_comb begin
        lk_hit  = 1'b0;
        lk_line = '0;
        lk_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            lk_idx = head_q + PTR_W'(i);
            if (valid_q[lk_idx] && (tag_q[lk_idx] == lk_addr[ADDR_W-1:OFF])) begin
                lk_hit  = 1'b1;
                lk_line = line_q[lk_idx];
            end
        end
    end

    assign empty = (count_q == '0);
    assign count = count_q;

    dcache_wbq_drain #(
        .LINE_WORDS (LINE_WORDS),
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W)
    ) u_drain (
        .clk          (clk),
        .rstn         (rstn),
        .head_valid_i (valid_q[head_q]),
        .head_addr_i  ({tag_q[head_q], {OFF{1'b0}}}),
        .head_line_i  (line_q[head_q]),
        .idle_o       (drain_idle),
        .free_o       (free),
        .aw_valid_o   (aw_valid),
        .aw_ready_i   (aw_ready),
        .aw_addr_o    (aw_addr),
        .aw_len_o     (aw_len),
        .aw_size_o    (aw_size),
        .w_valid_o    (w_valid),
        .w_ready_i    (w_ready),
        .w_data_o     (w_data),
        .w_strb_o     (w_strb),
        .w_last_o     (w_last),
        .b_valid_i    (b_valid),
        .b_ready_o    (b_ready)
    );

endmodule
